// File: rtl/dot_product.sv
// Pipelined signed dot product: registered products, a registered binary adder tree,
// then a width conversion into DotProduct. Optional clamp via DOT_PRODUCT_SATURATE_EN.
module dot_product #(
    parameter int unsigned INPUT_FEATURES = 4,
    parameter int unsigned INPUT_WIDTH    = 4,
    parameter int unsigned WEIGHT_WIDTH   = 8,
    parameter int unsigned OUTPUT_WIDTH   = 16
) (
    input  logic                                   Clock,
    input  logic                                   Reset,
    input  logic                                   start,
    input  logic [INPUT_FEATURES*INPUT_WIDTH-1:0]  A,
    input  logic [INPUT_FEATURES*WEIGHT_WIDTH-1:0] B,
    output logic [OUTPUT_WIDTH-1:0]                DotProduct,
    output logic                                   readEn
);

    localparam int unsigned Levels = $clog2(INPUT_FEATURES);
    localparam int unsigned ProdW  = INPUT_WIDTH + WEIGHT_WIDTH;
    localparam int unsigned SumW   = ProdW + Levels;

    // Number of operands alive at tree level lvl (level 0 holds the products).
    function automatic int unsigned level_cnt(int unsigned lvl);
        return (INPUT_FEATURES + (32'd1 << lvl) - 32'd1) >> lvl;
    endfunction

    // Level l is combinational from the registers of level l-1; every level except the
    // last is registered, the last one feeds the output register directly.
    for (genvar l = 0; l <= Levels; l++) begin : g_lvl
        localparam int unsigned Cnt = level_cnt(l);
        logic signed [SumW-1:0] sum_d [Cnt];

        if (l == 0) begin : g_mul
            logic signed [ProdW-1:0] a_ext;
            logic signed [ProdW-1:0] b_ext;
            logic signed [ProdW-1:0] prod;
            always_comb begin
                a_ext = '0;
                b_ext = '0;
                prod  = '0;
                for (int unsigned i = 0; i < Cnt; i++) begin
                    a_ext    = ProdW'($signed(A[i*INPUT_WIDTH +: INPUT_WIDTH]));
                    b_ext    = ProdW'($signed(B[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
                    prod     = a_ext * b_ext;
                    sum_d[i] = SumW'(prod);
                end
            end
        end else begin : g_add
            localparam int unsigned PrevCnt = level_cnt(l - 1);
            always_comb begin
                for (int unsigned j = 0; j < Cnt; j++) begin
                    if (2 * j + 1 < PrevCnt) begin
                        sum_d[j] = g_lvl[l-1].g_reg.sum_q[2*j] + g_lvl[l-1].g_reg.sum_q[2*j+1];
                    end else begin
                        sum_d[j] = g_lvl[l-1].g_reg.sum_q[2*j];
                    end
                end
            end
        end

        if (l < Levels) begin : g_reg
            // Data carries no reset; only the valid bits decide what reaches the output.
            logic signed [SumW-1:0] sum_q [Cnt];
            always_ff @(posedge Clock) begin
                sum_q <= sum_d;
            end
        end
    end

    logic signed [SumW-1:0]   final_sum;
    logic [OUTPUT_WIDTH-1:0] conv;

    assign final_sum = g_lvl[Levels].sum_d[0];

`ifdef DOT_PRODUCT_SATURATE_EN
    if (SumW > OUTPUT_WIDTH) begin : g_sat
        localparam int unsigned TopW = SumW - OUTPUT_WIDTH + 1;
        logic [TopW-1:0] top_bits;
        assign top_bits = final_sum[SumW-1:OUTPUT_WIDTH-1];
        // The sum fits only if every bit above the result sign bit matches it.
        always_comb begin
            conv = final_sum[OUTPUT_WIDTH-1:0];
            if (top_bits != '0 && top_bits != '1) begin
                conv = final_sum[SumW-1] ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}}
                                         : {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
            end
        end
    end else begin : g_ext
        assign conv = OUTPUT_WIDTH'(final_sum);
    end
`else
    assign conv = OUTPUT_WIDTH'(final_sum);
`endif

    logic [Levels:0]         valid_d;
    logic [Levels:0]         valid_q;
    logic [OUTPUT_WIDTH-1:0] dot_d;
    logic [OUTPUT_WIDTH-1:0] dot_q;

    always_comb begin
        valid_d    = '0;
        valid_d[0] = start;
        for (int unsigned i = 1; i <= Levels; i++) begin
            valid_d[i] = valid_q[i-1];
        end
        dot_d = dot_q;
        if (valid_d[Levels]) begin
            dot_d = conv;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            valid_q <= '0;
            dot_q   <= '0;
        end else begin
            valid_q <= valid_d;
            dot_q   <= dot_d;
        end
    end

    assign readEn     = valid_q[Levels];
    assign DotProduct = dot_q;

endmodule

// File: tb/tb_dot_product.sv
// Scoreboard bench for dot_product: four configurations share one random stimulus stream;
// expected results come from an integer reference model and are checked by a monitor.
module tb_dot_product;

    localparam int NDUT = 4;
    localparam int NF  [NDUT] = '{4, 1, 4, 3};
    localparam int OWD [NDUT] = '{16, 16, 8, 8};
    localparam int LAT [NDUT] = '{3, 1, 3, 3};

    typedef struct {
        logic [15:0] val;
        int          cyc;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        start;
    logic [15:0] a_pack;
    logic [31:0] b_pack;
    logic [15:0] dp0;
    logic [15:0] dp1;
    logic [7:0]  dp2;
    logic [7:0]  dp3;
    logic [NDUT-1:0] re;

    int   a_el [4];
    int   b_el [4];
    exp_t exp_q [NDUT][$];
    logic [15:0] last_dp [NDUT];
    bit   mon_en = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    dot_product #(.INPUT_FEATURES(4), .INPUT_WIDTH(4), .WEIGHT_WIDTH(8), .OUTPUT_WIDTH(16)) dut0 (
        .Clock(Clock), .Reset(Reset), .start(start), .A(a_pack), .B(b_pack),
        .DotProduct(dp0), .readEn(re[0])
    );
    dot_product #(.INPUT_FEATURES(1), .INPUT_WIDTH(4), .WEIGHT_WIDTH(8), .OUTPUT_WIDTH(16)) dut1 (
        .Clock(Clock), .Reset(Reset), .start(start), .A(a_pack[3:0]), .B(b_pack[7:0]),
        .DotProduct(dp1), .readEn(re[1])
    );
    dot_product #(.INPUT_FEATURES(4), .INPUT_WIDTH(4), .WEIGHT_WIDTH(8), .OUTPUT_WIDTH(8)) dut2 (
        .Clock(Clock), .Reset(Reset), .start(start), .A(a_pack), .B(b_pack),
        .DotProduct(dp2), .readEn(re[2])
    );
    dot_product #(.INPUT_FEATURES(3), .INPUT_WIDTH(4), .WEIGHT_WIDTH(8), .OUTPUT_WIDTH(8)) dut3 (
        .Clock(Clock), .Reset(Reset), .start(start), .A(a_pack[11:0]), .B(b_pack[23:0]),
        .DotProduct(dp3), .readEn(re[3])
    );

    function automatic logic [15:0] actual(int d);
        case (d)
            0:       return dp0;
            1:       return dp1;
            2:       return {8'h00, dp2};
            default: return {8'h00, dp3};
        endcase
    endfunction

    // Full-precision integer sum, then clamp or wrap into ow bits.
    function automatic logic [15:0] model(int n, int ow);
        longint s = 0;
        longint mx;
        longint mn;
        logic [15:0] r;
        for (int i = 0; i < n; i++) s += longint'(a_el[i]) * longint'(b_el[i]);
        mx = (longint'(1) << (ow - 1)) - 1;
        mn = -mx - 1;
`ifdef DOT_PRODUCT_SATURATE_EN
        if (s > mx) s = mx;
        else if (s < mn) s = mn;
`endif
        r = 16'(s);
        if (ow < 16) r = r & ((16'd1 << ow) - 16'd1);
        return r;
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d @cyc %0d: got %h, expected %h", name, d, cyc, act, exp);
        end
    endtask

    task automatic issue(input bit st);
        @(negedge Clock);
        start = st;
        for (int i = 0; i < 4; i++) begin
            a_pack[i*4 +: 4] = 4'(a_el[i]);
            b_pack[i*8 +: 8] = 8'(b_el[i]);
        end
        if (st && !Reset) begin
            for (int d = 0; d < NDUT; d++) begin
                exp_q[d].push_back('{val: model(NF[d], OWD[d]), cyc: cyc + LAT[d]});
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) issue(1'b0);
    endtask

    always @(posedge Clock) begin
        exp_t e;
        #1;
        if (mon_en) begin
            for (int d = 0; d < NDUT; d++) begin
                if (re[d]) begin
                    if (exp_q[d].size() == 0) begin
                        check("unexpected_readEn", d, 32'(re[d]), 32'd0);
                    end else begin
                        e = exp_q[d].pop_front();
                        check("latency", d, 32'(cyc), 32'(e.cyc));
                        check("result", d, 32'(actual(d)), 32'(e.val));
                        last_dp[d] = e.val;
                    end
                end else begin
                    check("hold", d, 32'(actual(d)), 32'(last_dp[d]));
                end
            end
        end
    end

    initial begin
        Reset  = 1'b1;
        start  = 1'b0;
        a_pack = '0;
        b_pack = '0;
        for (int d = 0; d < NDUT; d++) last_dp[d] = '0;
        for (int i = 0; i < 4; i++) begin
            a_el[i] = 0;
            b_el[i] = 0;
        end
        repeat (3) @(negedge Clock);
        for (int d = 0; d < NDUT; d++) begin
            check("reset_readEn", d, 32'(re[d]), 32'd0);
            check("reset_dp", d, 32'(actual(d)), 32'd0);
        end
        mon_en = 1'b1;
        Reset  = 1'b0;

        a_el = '{1, 2, 3, 4};
        b_el = '{5, 6, 7, 8};
        issue(1'b1);
        idle(5);

        a_el = '{-8, -8, -8, -8};
        b_el = '{127, 127, 127, 127};
        issue(1'b1);
        idle(5);

        // Back-to-back: 70, 0, -4064.
        a_el = '{1, 2, 3, 4};
        b_el = '{5, 6, 7, 8};
        issue(1'b1);
        a_el = '{0, 0, 0, 0};
        issue(1'b1);
        a_el = '{-8, -8, -8, -8};
        b_el = '{127, 127, 127, 127};
        issue(1'b1);
        idle(6);

        // Reset one cycle after a start pulse: the pair must vanish.
        a_el = '{1, 2, 3, 4};
        b_el = '{5, 6, 7, 8};
        issue(1'b1);
        @(negedge Clock);
        start = 1'b0;
        Reset = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            exp_q[d].delete();
            last_dp[d] = '0;
        end
        @(negedge Clock);
        for (int d = 0; d < NDUT; d++) begin
            check("midreset_readEn", d, 32'(re[d]), 32'd0);
            check("midreset_dp", d, 32'(actual(d)), 32'd0);
        end
        Reset = 1'b0;
        idle(5);

        a_el = '{3, -1, 7, -8};
        b_el = '{-2, 100, -128, -128};
        issue(1'b1);
        idle(4);

        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 4; i++) begin
                a_el[i] = int'($urandom_range(15)) - 8;
                b_el[i] = int'($urandom_range(255)) - 128;
            end
            issue($urandom_range(3) != 0);
        end
        idle(10);

        for (int d = 0; d < NDUT; d++) begin
            check("drained", d, 32'(exp_q[d].size()), 32'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
